// File: rtl/stream_mux_pkg.sv
// stream_mux_pkg: shared mode constants and the rotated first-set search for stream_mux_rr.
//   MODE_FIXED / MODE_RR : values of the stream_mux_rr mode input
//   rr_first             : index of the first set bit of v[n-1:0], searching from ptr and wrapping; -1 if none
package stream_mux_pkg;
  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;
  // The search runs downward so the candidate nearest ptr is written last and wins.
  function automatic int rr_first(input logic [15:0] v, input int ptr, input int n);
    int r;
    r = -1;
    for (int k = n - 1; k >= 0; k--) if (v[(ptr + k) % n]) r = (ptr + k) % n;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin grant with pointer update.
//   in_valid : per-channel request
//   rr_ptr   : channel with highest priority this cycle
//   advance  : the granted channel finished its unit; move the pointer past it
//   grant    : one-hot grant, zero when nothing requests
//   next_ptr : pointer value for the next cycle
module rr_arbiter
  import stream_mux_pkg::*;
#(
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic [N_IN-1:0]  in_valid,
  input  logic [SEL_W-1:0] rr_ptr,
  input  logic             advance,
  output logic [N_IN-1:0]  grant,
  output logic [SEL_W-1:0] next_ptr
);
  int w_first;
  always_comb begin
    w_first  = rr_first(16'(in_valid), int'(rr_ptr), N_IN);
    grant    = (w_first >= 0) ? N_IN'(1) << w_first : '0;
    next_ptr = !advance ? rr_ptr : (w_first == N_IN - 1) ? '0 : SEL_W'(w_first + 1);
  end
endmodule

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N_IN-to-1 valid/ready stream mux, fixed-select or round-robin, one registered output stage.
//   clk, rst_n          : clock, synchronous active-low reset
//   mode, sel           : 0 = take channel sel, 1 = round-robin among valid channels
//   in_data/valid/ready : packed input channels, channel i at [i*WIDTH +: WIDTH]
//   out_data/valid/ready, out_src : registered output beat and the channel it came from
//   STREAM_MUX_LAST_EN  : adds in_last/out_last; in round-robin a multi-beat packet holds the grant until its last beat
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N_IN  = 4,
  localparam int SEL_W = $clog2(N_IN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  input  logic [N_IN-1:0]       in_valid,
  output logic [N_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_src
`ifdef STREAM_MUX_LAST_EN
  ,
  input  logic [N_IN-1:0]       in_last,
  output logic                  out_last
`endif
);
  logic [N_IN-1:0]  w_grant, w_arb_grant, w_arb_valid;
  logic [SEL_W-1:0] w_gidx, w_next_ptr;
  logic             w_can_load, w_acc, w_adv, w_last;
  logic [WIDTH-1:0] w_data;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic [SEL_W-1:0] r_src, r_ptr;
`ifdef STREAM_MUX_LAST_EN
  logic             r_locked, r_last;
  logic [SEL_W-1:0] r_lock_ch;
  // While locked only the owning channel may request, so others see no ready.
  assign w_arb_valid = r_locked ? in_valid & (N_IN'(1) << r_lock_ch) : in_valid;
  assign w_last      = in_last[w_gidx];
  assign out_last    = r_last;
`else
  assign w_arb_valid = in_valid;
  assign w_last      = 1'b1;
`endif
  rr_arbiter #(.N_IN(N_IN)) u_arb (
    .in_valid (w_arb_valid),
    .rr_ptr   (r_ptr),
    .advance  (w_adv),
    .grant    (w_arb_grant),
    .next_ptr (w_next_ptr)
  );
  always_comb begin
    w_can_load = !r_valid || out_ready;
    w_grant    = (mode == MODE_RR) ? w_arb_grant : (int'(sel) < N_IN) ? N_IN'(1) << sel : '0;
    in_ready   = (rst_n && w_can_load) ? w_grant : '0;
    w_acc      = |(in_valid & in_ready);
    w_gidx     = '0;
    for (int i = 0; i < N_IN; i++) if (w_grant[i]) w_gidx = SEL_W'(i);
    w_data     = in_data[w_gidx*WIDTH +: WIDTH];
    w_adv      = w_acc && (mode == MODE_RR) && w_last;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_data    <= '0;
      r_src     <= '0;
      r_ptr     <= '0;
`ifdef STREAM_MUX_LAST_EN
      r_locked  <= 1'b0;
      r_lock_ch <= '0;
      r_last    <= 1'b0;
`endif
    end else begin
      if (w_acc) begin
        r_data  <= w_data;
        r_src   <= w_gidx;
        r_valid <= 1'b1;
      end else if (out_ready) r_valid <= 1'b0;
      r_ptr <= w_next_ptr;
`ifdef STREAM_MUX_LAST_EN
      if (w_acc) r_last <= w_last;
      if (w_acc) r_lock_ch <= w_gidx;
      r_locked <= (mode == MODE_RR) && (w_acc ? !w_last : r_locked);
`endif
    end
  end
  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_src   = r_src;
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed self-checking bench for stream_mux_rr (N_IN=4, plus an N_IN=3 instance for out-of-range sel).
module tb_stream_mux_rr;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [1:0]  sel;
  logic [127:0] in_data;
  logic [3:0]  in_valid, in_ready;
  logic [31:0] out_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_src;
  logic [95:0] in_data3;
  logic [2:0]  in_valid3, in_ready3;
  logic [31:0] out_data3;
  logic        out_valid3;
  logic [1:0]  out_src3;
  int n_chk = 0;
  int n_fail = 0;
`ifdef STREAM_MUX_LAST_EN
  logic [3:0] in_last;
  logic       out_last;
  logic [2:0] in_last3 = '0;
  logic       out_last3;
`endif

  always #5 clk = ~clk;

  stream_mux_rr #(.WIDTH(32), .N_IN(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src)
`ifdef STREAM_MUX_LAST_EN
    , .in_last(in_last), .out_last(out_last)
`endif
  );

  stream_mux_rr #(.WIDTH(32), .N_IN(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .sel(2'd3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_ready(1'b1), .out_src(out_src3)
`ifdef STREAM_MUX_LAST_EN
    , .in_last(in_last3), .out_last(out_last3)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_valid = '0; out_ready = 1'b0;
    in_data = {32'h33333333, 32'hDEADBEEF, 32'h22222222, 32'h11111111};
    in_data3 = {32'h3C3C3C3C, 32'h2B2B2B2B, 32'h1A1A1A1A};
    in_valid3 = 3'b111;
`ifdef STREAM_MUX_LAST_EN
    in_last = 4'b1111;
`endif
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_src", 64'(out_src), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);

    // fixed mode, sel=2
    rst_n = 1'b1; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
    #1;
    chk("fix_in_ready", 64'(in_ready), 64'b0100);
    chk("n3_sel3_in_ready", 64'(in_ready3), 64'd0);
    tick();
    chk("fix_out_data", 64'(out_data), 64'hDEADBEEF);
    chk("fix_out_src", 64'(out_src), 64'd2);
    chk("fix_out_valid", 64'(out_valid), 64'd1);
    chk("n3_out_valid", 64'(out_valid3), 64'd0);
    in_valid = 4'b0001;
    #1;
    chk("fix_ready_no_valid", 64'(in_ready), 64'b0100);
    tick();
    chk("fix_drain_valid", 64'(out_valid), 64'd0);
    chk("fix_drain_data_hold", 64'(out_data), 64'hDEADBEEF);
    tick();
    chk("fix_idle_valid", 64'(out_valid), 64'd0);
    chk("n3_idle_ready", 64'(in_ready3), 64'd0);

    // round-robin, all valid
    in_data = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
    mode = 1'b1; in_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("rr_src", 64'(out_src), 64'(k % 4));
      chk("rr_data", 64'(out_data), 64'(32'hA0000000 + 32'(k % 4)));
      chk("rr_valid", 64'(out_valid), 64'd1);
    end

    // stall with held beat (src 1), pointer at 2
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall_src", 64'(out_src), 64'd1);
      chk("stall_data", 64'(out_data), 64'hA0000001);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("reload_in_ready", 64'(in_ready), 64'b0100);
    tick();
    chk("reload_src", 64'(out_src), 64'd2);
    chk("reload_valid", 64'(out_valid), 64'd1);

    // reset while holding a beat, pointer at 3
    out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("rst_mid_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("rst_mid_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_data", 64'(out_data), 64'd0);
    chk("rst_mid_src", 64'(out_src), 64'd0);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("rst_first_grant", 64'(out_src), 64'd0);
    chk("rst_first_valid", 64'(out_valid), 64'd1);

    // sparse requests with wrap: pointer at 1, valid {3,1}
    in_valid = 4'b1010;
    #1;
    chk("sparse_ready_1", 64'(in_ready), 64'b0010);
    tick();
    chk("sparse_src_1", 64'(out_src), 64'd1);
    chk("sparse_ready_3", 64'(in_ready), 64'b1000);
    tick();
    chk("sparse_src_3", 64'(out_src), 64'd3);
    tick();
    chk("sparse_src_wrap", 64'(out_src), 64'd1);

    // switch to fixed mode mid-stream: held beat untouched, grant follows sel
    out_ready = 1'b0; mode = 1'b0; sel = 2'd0;
    #1;
    chk("switch_hold_src", 64'(out_src), 64'd1);
    chk("switch_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    #1;
    chk("switch_ready_sel0", 64'(in_ready), 64'b0001);

`ifdef STREAM_MUX_LAST_EN
    rst_n = 1'b0; in_valid = '0;
    tick();
    rst_n = 1'b1; mode = 1'b1; in_valid = 4'b0110; in_last = 4'b1100;
    #1;
    chk("lock_ready_b1", 64'(in_ready), 64'b0010);
    tick();
    chk("lock_src_b1", 64'(out_src), 64'd1);
    chk("lock_last_b1", 64'(out_last), 64'd0);
    in_valid = 4'b0100;
    #1;
    chk("lock_idle_ready", 64'(in_ready), 64'd0);
    in_valid = 4'b0110;
    #1;
    chk("lock_ready_b2", 64'(in_ready), 64'b0010);
    tick();
    chk("lock_src_b2", 64'(out_src), 64'd1);
    in_last = 4'b1110;
    #1;
    chk("lock_ready_b3", 64'(in_ready), 64'b0010);
    tick();
    chk("lock_src_b3", 64'(out_src), 64'd1);
    chk("lock_last_b3", 64'(out_last), 64'd1);
    chk("unlock_ready", 64'(in_ready), 64'b0100);
    tick();
    chk("unlock_src", 64'(out_src), 64'd2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
